// File: rtl/mult_div_if.sv
// mult_div_if: request/result bus between a requester (master) and mult_div (slave)
interface mult_div_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    modport master (output start, op, a, b, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mult_div.sv
// mult_div: 32-cycle iterative MULTU/MULT/DIVU/DIV unit; define MULT_DIV_DIVIDE_EN to build the divider
module mult_div (
    input  logic      clk,
    input  logic      rst,
    mult_div_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t      r_state;
    logic [1:0]  r_op;
    logic        r_sa;
    logic        r_sb;
    logic [31:0] r_m;
    logic [31:0] r_p;
    logic [31:0] r_q;
    logic [4:0]  r_cnt;
    logic [31:0] w_ma;
    logic [31:0] w_mb;
    logic [32:0] w_sum;
    logic [31:0] w_div_p;
    logic [31:0] w_div_q;
    logic [31:0] w_nxt_p;
    logic [31:0] w_nxt_q;
    logic        w_neg;
    logic [63:0] w_mres;
    logic [31:0] w_hi;
    logic [31:0] w_lo;
`ifdef MULT_DIV_DIVIDE_EN
    logic [32:0] w_rs;
    logic        w_ge;
`endif
    // Operand magnitudes; the signs are kept aside and applied when the result is loaded
    always_comb begin
        w_ma = (bus.op[0] && bus.a[31]) ? -bus.a : bus.a;
        w_mb = (bus.op[0] && bus.b[31]) ? -bus.b : bus.b;
    end
    // One iteration: shift-add on {r_p,r_q} for multiply, restoring shift-subtract for divide
    always_comb begin
        w_sum = {1'b0, r_p} + (r_q[0] ? {1'b0, r_m} : 33'd0);
`ifdef MULT_DIV_DIVIDE_EN
        w_rs    = {r_p, r_q[31]};
        w_ge    = w_rs >= {1'b0, r_m};
        w_div_p = w_ge ? w_rs[31:0] - r_m : w_rs[31:0];
        w_div_q = {r_q[30:0], w_ge};
`else
        w_div_p = '0;
        w_div_q = '0;
`endif
        w_nxt_p = r_op[1] ? w_div_p : w_sum[32:1];
        w_nxt_q = r_op[1] ? w_div_q : {w_sum[0], r_q[31:1]};
    end
    // Sign fix-up of the final iteration's output; a zero divisor forces an all-ones quotient
    always_comb begin
        w_neg  = r_op[0] && (r_sa ^ r_sb);
        w_mres = w_neg ? -{w_nxt_p, w_nxt_q} : {w_nxt_p, w_nxt_q};
`ifdef MULT_DIV_DIVIDE_EN
        w_hi = !r_op[1] ? w_mres[63:32] : (r_op[0] && r_sa) ? -w_nxt_p : w_nxt_p;
        w_lo = !r_op[1] ? w_mres[31:0] : (r_m == '0) ? '1 : w_neg ? -w_nxt_q : w_nxt_q;
`else
        w_hi = r_op[1] ? '0 : w_mres[63:32];
        w_lo = r_op[1] ? '0 : w_mres[31:0];
`endif
    end
    // Control FSM with registered busy/done/hi/lo
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_op     <= '0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_m      <= '0;
            r_p      <= '0;
            r_q      <= '0;
            r_cnt    <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.hi   <= '0;
            bus.lo   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        r_op     <= bus.op;
                        r_sa     <= bus.a[31];
                        r_sb     <= bus.b[31];
                        r_m      <= w_mb;
                        r_q      <= w_ma;
                        r_p      <= '0;
                        r_cnt    <= '0;
                        bus.busy <= 1'b1;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    r_p   <= w_nxt_p;
                    r_q   <= w_nxt_q;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        bus.hi   <= w_hi;
                        bus.lo   <= w_lo;
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div.sv
// tb_mult_div: directed self-checking bench for mult_div (divide results depend on MULT_DIV_DIVIDE_EN)
module tb_mult_div;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   cnt;
    int   last;
`ifdef MULT_DIV_DIVIDE_EN
    localparam bit DE = 1'b1;
`else
    localparam bit DE = 1'b0;
`endif
    mult_div_if bus ();
    mult_div dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    function automatic logic [31:0] dv(input logic [31:0] x);
        return DE ? x : 32'h0;
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el);
        int n;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        chk({tag, " busy"}, 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        bus.op    = ~op;
        bus.a     = ~a;
        bus.b     = b + 32'd1;
        n = 0;
        while (!bus.done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'd32);
        chk({tag, " hi"}, bus.hi, eh);
        chk({tag, " lo"}, bus.lo, el);
        chk({tag, " busy_end"}, 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, " done_pulse"}, 32'(bus.done), 32'd0);
        chk({tag, " hold"}, bus.lo, el);
    endtask
    initial begin
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        #12;
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst done", 32'(bus.done), 32'd0);
        chk("rst hi", bus.hi, 32'd0);
        chk("rst lo", bus.lo, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run("mult_minsq", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run("mult_m1", 2'b01, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
        run("multu_carry", 2'b00, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000);
        run("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, dv(32'h0), dv(32'h8000_0000));
        run("div_neg", 2'b11, 32'hFFFF_FFF9, 32'h0000_0002, dv(32'hFFFF_FFFF), dv(32'hFFFF_FFFD));
        run("div_negb", 2'b11, 32'h0000_0007, 32'hFFFF_FFFE, dv(32'h0000_0001), dv(32'hFFFF_FFFD));
        run("divu", 2'b10, 32'h0000_0064, 32'h0000_0007, dv(32'h0000_0002), dv(32'h0000_000E));
        run("divu_z", 2'b10, 32'h0000_1234, 32'h0000_0000, dv(32'h0000_1234), dv(32'hFFFF_FFFF));
        run("div_z", 2'b11, 32'hFFFF_FFF8, 32'h0000_0000, dv(32'hFFFF_FFF8), dv(32'hFFFF_FFFF));
        run("divu_10_3", 2'b10, 32'h0000_000A, 32'h0000_0003, dv(32'h0000_0001), dv(32'h0000_0003));
        run("multu_6x7", 2'b00, 32'h0000_0006, 32'h0000_0007, 32'h0, 32'h0000_002A);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.a     = 32'd3;
        bus.b     = 32'd4;
        cnt  = 0;
        last = -1;
        for (int i = 0; i < 102; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                cnt++;
                last = i;
            end
        end
        bus.start = 1'b0;
        chk("held dones", 32'(cnt), 32'd3);
        chk("held last", 32'(last), 32'd100);
        chk("held lo", bus.lo, 32'd12);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'hFFFF_FFFF;
        bus.b     = 32'hFFFF_FFFF;
        @(posedge clk);
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort busy", 32'(bus.busy), 32'd0);
        chk("abort done", 32'(bus.done), 32'd0);
        chk("abort hi", bus.hi, 32'd0);
        chk("abort lo", bus.lo, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done) cnt++;
        end
        chk("abort no_done", 32'(cnt), 32'd0);
        run("after_rst", 2'b00, 32'h0000_0006, 32'h0000_0007, 32'h0, 32'h0000_002A);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mult_div.md
MULT_DIV -- requirements
Module: mult_div

Interface
REQ-001 Parameters: none; datapath fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request new operation; sampled only in IDLE.
REQ-005 op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 a  input  32  multiplicand / dividend.
REQ-007 b  input  32  multiplier / divisor.
REQ-008 busy  output  1  high while iterating.
REQ-009 done  output  1  one-cycle pulse, result valid; drives en of downstream HI/LO registers.
REQ-010 hi  output  32  product[63:32] or remainder.
REQ-011 lo  output  32  product[31:0] or quotient.

Function
REQ-012 FSM states SHALL be IDLE, RUN and DONE.
- IDLE->RUN on start=1.
- RUN->DONE after 32 iterations.
- DONE->IDLE unconditionally.
REQ-013 At edge N with start=1 in IDLE, the block SHALL latch op, a and b, clear the iteration counter and set busy=1.
REQ-014 Edges N+1..N+32 SHALL each perform one shift-add (multiply) or shift-subtract restoring step (divide).
REQ-015 At edge N+32 the block SHALL load hi/lo with the final result, set done=1 and clear busy, giving fixed latency 32 cycles from acceptance to done.
REQ-016 done SHALL be high for exactly one cycle; hi/lo SHALL hold their value until the next done or reset.
REQ-017 start in RUN or DONE SHALL be ignored; a/b/op changes after acceptance SHALL not affect the result; minimum start-to-start spacing is 34 cycles.
REQ-018 MULT/DIV SHALL operate on operand magnitudes and fix signs at completion.
- Product is negated if the operand signs differ.
- Quotient is negated if the signs differ.
- Remainder takes the sign of the dividend.
REQ-019 MULTU/MULT SHALL produce the exact 64-bit product; no overflow is possible.
REQ-020 Divide by zero (b=0, DIVU or DIV) SHALL give lo=32'hFFFF_FFFF and hi=a, with normal latency.
REQ-021 DIV with a=32'h8000_0000 and b=32'hFFFF_FFFF SHALL give lo=32'h8000_0000 and hi=0.

Reset
REQ-022 rst=1 SHALL immediately, without waiting for clk, force IDLE, busy=0, done=0, hi=0, lo=0 and clear latched operands and the counter.
REQ-023 Reset during RUN or DONE SHALL abort the operation; no done pulse SHALL follow for the aborted operation.
REQ-024 After rst deasserts, the first rising edge with start=1 SHALL be accepted.

Configuration
REQ-025 Macro MULT_DIV_DIVIDE_EN: when defined, DIVU/DIV SHALL behave per REQ-014..REQ-021.
REQ-026 When MULT_DIV_DIVIDE_EN is not defined, the divider datapath SHALL be omitted.
- op=10/11 SHALL still be accepted and complete with normal latency and a done pulse.
- Result is hi=0, lo=0.
- MULTU/MULT are unaffected.

Verification
REQ-027 MULTU a=FFFFFFFF b=FFFFFFFF -> busy 32 cycles, then done pulse with hi=FFFFFFFE, lo=00000001.
REQ-028 MULT a=FFFFFFFD (-3) b=00000007 -> hi=FFFFFFFF, lo=FFFFFFEB; signed overflow DIV 80000000/FFFFFFFF -> lo=80000000, hi=00000000.
REQ-029 DIV a=FFFFFFF9 (-7) b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF; DIVU a=00000064 b=00000007 -> lo=0000000E, hi=00000002.
REQ-030 DIVU a=00001234 b=00000000 -> lo=FFFFFFFF, hi=00001234, done at normal latency.
REQ-031 Stimulus and required response for start/reset cases:
- start held high through RUN -> exactly one done per 34 cycles.
- rst pulse at iteration 10 -> busy, done, hi and lo are 0 before the next clk edge, and no done follows.
REQ-032 Build without MULT_DIV_DIVIDE_EN, DIVU a=0000000A b=00000003 -> done after 32 cycles with hi=0, lo=0; MULTU 6x7 -> lo=0000002A, hi=0.
